// File: rtl/i2s_tx_master.sv
// i2s_tx_master
//
// I2S master transmitter. Divides m_clk down to SCK, generates LRCLK and
// serialises 24-bit stereo pairs MSB first with the standard one-SCK I2S delay
// after each LRCLK transition. Pairs arrive through a valid/ready handshake into
// a one-pair staging register; at each frame boundary the staged pair moves to
// the holding register that feeds the shifter.
//
// Ports:
//   m_clk        master clock, all logic on its rising edge
//   rst          asynchronous active-high reset
//   enable       run request, sampled every cycle
//   tx_left      left sample (two's complement)
//   tx_right     right sample (two's complement)
//   tx_valid     sample pair valid
//   tx_ready     staging register empty; transfer on tx_valid & tx_ready
//   i2s_sck      bit clock
//   i2s_lrclk    word select, 0 = left, 1 = right
//   i2s_sdout    serial data
//   frame_start  one-cycle pulse following each frame load
//   underrun     one-cycle pulse when a frame load found staging empty
//
// Build option:
//   I2S_TX_UNDERRUN_REPEAT_EN  when defined, an underrun retransmits the
//                              previous pair instead of sending a muted frame.
module i2s_tx_master #(
    parameter int unsigned SCK_DIV = 16,
    parameter int unsigned SLOT_W  = 32,
    parameter int unsigned DATA_W  = 24
) (
    input  logic              m_clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] tx_left,
    input  logic [DATA_W-1:0] tx_right,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              i2s_sck,
    output logic              i2s_lrclk,
    output logic              i2s_sdout,
    output logic              frame_start,
    output logic              underrun
);

    localparam int unsigned DIV_BITS  = $clog2(SCK_DIV);
    localparam int unsigned SLOT_BITS = $clog2(SLOT_W);
    localparam int unsigned BIT_BITS  = SLOT_BITS + 1;
    localparam int unsigned PAD       = SLOT_W - DATA_W - 1;

    localparam logic [DIV_BITS-1:0] DIV_LAST = DIV_BITS'(SCK_DIV - 1);
    localparam logic [DIV_BITS-1:0] DIV_HALF = DIV_BITS'(SCK_DIV / 2);
    localparam logic [BIT_BITS-1:0] BIT_LAST = BIT_BITS'(2 * SLOT_W - 1);

    typedef enum logic {StIdle, StRun} state_e;

    state_e                  state_q, state_d;
    logic [DIV_BITS-1:0]     div_q, div_d;
    logic [BIT_BITS-1:0]     bit_q, bit_d;
    logic [2*DATA_W-1:0]     stage_q, stage_d;
    logic                    stage_full_q, stage_full_d;
    // Holding layout is {left, right}.
    logic [2*DATA_W-1:0]     hold_q, hold_d;

    logic                    sck_q, sck_d;
    logic                    lrclk_q, lrclk_d;
    logic                    sdout_q, sdout_d;
    logic                    fs_q, fs_d;
    logic                    ur_q, ur_d;

    logic                    accept;
    logic                    load;
    logic                    run_d;
    logic [SLOT_BITS-1:0]    p_inv;
    logic [DATA_W-1:0]       word;
    logic [SLOT_W-1:0]       slot_word;

    // Sequencing, staging and holding next-state.
    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        bit_d        = bit_q;
        stage_d      = stage_q;
        stage_full_d = stage_full_q;
        hold_d       = hold_q;
        load         = 1'b0;
        accept       = tx_valid && !stage_full_q;

        unique case (state_q)
            StIdle: begin
                div_d = '0;
                bit_d = '0;
                if (enable) begin
                    state_d = StRun;
                    load    = 1'b1;
                end
            end
            StRun: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (bit_q == BIT_LAST) begin
                        // Frame boundary: enable is only honoured here, so a
                        // frame is never cut short.
                        bit_d = '0;
                        if (enable) begin
                            load = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        bit_d = bit_q + BIT_BITS'(1);
                    end
                end else begin
                    div_d = div_q + DIV_BITS'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        fs_d = load;
        // A pair accepted in the load cycle is too late for this frame.
        ur_d = load && !stage_full_q;

        if (load) begin
            if (stage_full_q) begin
                hold_d       = stage_q;
                stage_full_d = 1'b0;
            end else begin
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
                hold_d = hold_q;
`else
                hold_d = '0;
`endif
            end
        end

        if (accept) begin
            stage_d      = {tx_left, tx_right};
            stage_full_d = 1'b1;
        end
    end

    // Line outputs are computed from next-state so the registered pins line up
    // with the counters they describe; lrclk/sdout therefore move with SCK fall.
    always_comb begin
        run_d     = (state_d == StRun);
        p_inv     = ~bit_d[SLOT_BITS-1:0];
        lrclk_d   = run_d && bit_d[SLOT_BITS];
        word      = bit_d[SLOT_BITS] ? hold_d[DATA_W-1:0] : hold_d[2*DATA_W-1:DATA_W];
        // Slot image MSB-first: position p sits at index SLOT_W-1-p, i.e. ~p.
        // Bit 0 is the I2S delay slot, the tail after the LSB pads with zero.
        slot_word = SLOT_W'({1'b0, word}) << PAD;
        sck_d     = run_d && (div_d >= DIV_HALF);
        sdout_d   = run_d && slot_word[p_inv];
    end

    always_ff @(posedge m_clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            div_q        <= '0;
            bit_q        <= '0;
            stage_q      <= '0;
            stage_full_q <= 1'b0;
            hold_q       <= '0;
            sck_q        <= 1'b0;
            lrclk_q      <= 1'b0;
            sdout_q      <= 1'b0;
            fs_q         <= 1'b0;
            ur_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            bit_q        <= bit_d;
            stage_q      <= stage_d;
            stage_full_q <= stage_full_d;
            hold_q       <= hold_d;
            sck_q        <= sck_d;
            lrclk_q      <= lrclk_d;
            sdout_q      <= sdout_d;
            fs_q         <= fs_d;
            ur_q         <= ur_d;
        end
    end

    assign tx_ready    = !stage_full_q;
    assign i2s_sck     = sck_q;
    assign i2s_lrclk   = lrclk_q;
    assign i2s_sdout   = sdout_q;
    assign frame_start = fs_q;
    assign underrun    = ur_q;

endmodule

// File: tb/tb_i2s_tx_master.sv
// tb_i2s_tx_master
//
// Self-checking bench for i2s_tx_master at default parameters. A bus-model
// receiver captures one 64-bit slot image per frame on SCK rising edges; frame
// contents, handshake timing and line timing are compared with hand-derived
// constants. Honours I2S_TX_UNDERRUN_REPEAT_EN for the underrun expectations.
`timescale 1ns/1ps
module tb_i2s_tx_master;

    localparam int unsigned SCK_DIV = 16;
    localparam int unsigned SLOT_W  = 32;
    localparam int unsigned DATA_W  = 24;
    localparam int          FRAME   = 1024;
    localparam logic [63:0] ZMASK   = 64'hFE00_0001_FE00_0001;
    localparam logic [63:0] LR_PAT  = 64'hFFFF_FFFF_0000_0000;

    logic              m_clk = 1'b0;
    logic              rst = 1'b0;
    logic              enable = 1'b0;
    logic              tx_valid = 1'b0;
    logic [DATA_W-1:0] tx_left = '0;
    logic [DATA_W-1:0] tx_right = '0;
    logic              tx_ready;
    logic              i2s_sck;
    logic              i2s_lrclk;
    logic              i2s_sdout;
    logic              frame_start;
    logic              underrun;

    i2s_tx_master #(
        .SCK_DIV(SCK_DIV),
        .SLOT_W (SLOT_W),
        .DATA_W (DATA_W)
    ) dut (
        .m_clk      (m_clk),
        .rst        (rst),
        .enable     (enable),
        .tx_left    (tx_left),
        .tx_right   (tx_right),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .i2s_sck    (i2s_sck),
        .i2s_lrclk  (i2s_lrclk),
        .i2s_sdout  (i2s_sdout),
        .frame_start(frame_start),
        .underrun   (underrun)
    );

    always #5 m_clk = ~m_clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge m_clk) cyc <= cyc + 1;

    // ---------------- bus-model receiver ----------------
    typedef struct {
        logic [63:0] sd;
        logic [63:0] lr;
        logic        ur;
    } frame_t;

    frame_t rxq[$];
    frame_t cur;
    int     rise_t[$];
    int     rx_idx = 0;
    logic   prev_sck = 1'b0;
    int     fs_cnt = 0;
    int     ur_cnt = 0;
    int     ur_alone = 0;

    always @(negedge m_clk) begin
        if (rst) begin
            rx_idx   = 0;
            prev_sck = 1'b0;
        end else begin
            if (frame_start) begin
                fs_cnt++;
                rx_idx = 0;
                cur.ur = underrun;
                cur.sd = '0;
                cur.lr = '0;
            end
            if (underrun) begin
                ur_cnt++;
                if (!frame_start) ur_alone++;
            end
            if (i2s_sck && !prev_sck) begin
                rise_t.push_back(cyc);
                if (rx_idx < 64) begin
                    cur.sd[rx_idx] = i2s_sdout;
                    cur.lr[rx_idx] = i2s_lrclk;
                    rx_idx++;
                    if (rx_idx == 64) rxq.push_back(cur);
                end
            end
            prev_sck = i2s_sck;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge m_clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    // Present a pair and hold tx_valid until the DUT takes it.
    task automatic push_pair(input logic [23:0] l, input logic [23:0] r,
                             input string name, output int t_acc);
        bit done = 1'b0;
        t_acc    = -1;
        tx_left  = l;
        tx_right = r;
        tx_valid = 1'b1;
        for (int n = 0; n < 3 * FRAME && !done; n++) begin
            if (tx_ready) begin
                tick();
                t_acc = cyc;
                done  = 1'b1;
            end else begin
                tick();
            end
        end
        tx_valid = 1'b0;
        check({name, "_accepted"}, 64'(done), 64'd1);
    endtask

    task automatic wait_frames(input int n, input int budget, input string name);
        int k = 0;
        while (rxq.size() < n && k < budget) begin
            tick();
            k++;
        end
        check({name, "_frames_rx"}, 64'(rxq.size() >= n), 64'd1);
    endtask

    task automatic check_frame(input int idx, input logic [23:0] el, input logic [23:0] er,
                               input logic eur, input string name);
        logic [23:0] l;
        logic [23:0] r;
        if (idx >= rxq.size()) begin
            checks++;
            failures++;
            $display("FAIL %s: frame %0d missing, got %0d frames", name, idx, rxq.size());
        end else begin
            for (int k = 0; k < 24; k++) begin
                l[23-k] = rxq[idx].sd[1+k];
                r[23-k] = rxq[idx].sd[33+k];
            end
            check({name, "_left"}, 64'(l), 64'(el));
            check({name, "_right"}, 64'(r), 64'(er));
            check({name, "_zero_bits"}, rxq[idx].sd & ZMASK, 64'd0);
            check({name, "_lrclk"}, rxq[idx].lr, LR_PAT);
            check({name, "_underrun"}, 64'(rxq[idx].ur), 64'(eur));
        end
    endtask

    // ---------------- stimulus table ----------------
    typedef struct {
        logic        supply;
        logic [23:0] l;
        logic [23:0] r;
        logic [23:0] exp_l;
        logic [23:0] exp_r;
        logic        exp_ur;
    } vec_t;

    localparam int NV = 5;
    vec_t vec[NV];
    int   acc_t[NV];

    initial begin
        int en;
        int t;
        int base_rx;
        int base_fs;
        int base_ur;

        vec[0] = '{1'b1, 24'h123456, 24'hABCDEF, 24'h123456, 24'hABCDEF, 1'b0};
        vec[1] = '{1'b1, 24'h800000, 24'h7FFFFF, 24'h800000, 24'h7FFFFF, 1'b0};
        vec[2] = '{1'b1, 24'h000001, 24'hFFFFFE, 24'h000001, 24'hFFFFFE, 1'b0};
        vec[3] = '{1'b1, 24'hC3C3C3, 24'h3C3C3C, 24'hC3C3C3, 24'h3C3C3C, 1'b0};
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
        vec[4] = '{1'b0, 24'h0, 24'h0, 24'hC3C3C3, 24'h3C3C3C, 1'b1};
`else
        vec[4] = '{1'b0, 24'h0, 24'h0, 24'h000000, 24'h000000, 1'b1};
`endif
        for (int i = 0; i < NV; i++) acc_t[i] = -1;

        // ---- reset ----
        rst = 1'b1;
        repeat (3) tick();
        check("rst_sck", 64'(i2s_sck), 64'd0);
        check("rst_lrclk", 64'(i2s_lrclk), 64'd0);
        check("rst_sdout", 64'(i2s_sdout), 64'd0);
        check("rst_frame_start", 64'(frame_start), 64'd0);
        check("rst_underrun", 64'(underrun), 64'd0);
        check("rst_tx_ready", 64'(tx_ready), 64'd1);
        rst = 1'b0;
        rise_t.delete();
        repeat (40) tick();
        check("idle_no_sck", 64'(rise_t.size()), 64'd0);
        check("idle_tx_ready", 64'(tx_ready), 64'd1);

        // ---- single frame, enable dropped at bit 10 ----
        push_pair(24'hA5A5A5, 24'h5A5A5A, "single_push", t);
        check("single_ready_low", 64'(tx_ready), 64'd0);
        rise_t.delete();
        base_rx = rxq.size();
        base_fs = fs_cnt;
        base_ur = ur_cnt;
        enable = 1'b1;
        en = cyc;
        tick();
        check("single_frame_start", 64'(frame_start), 64'd1);
        check("single_no_underrun", 64'(underrun), 64'd0);
        check("single_ready_back", 64'(tx_ready), 64'd1);
        wait_until(en + 16);
        check("single_delay_slot", 64'(i2s_sdout), 64'd0);
        tick();
        check("single_left_msb", 64'(i2s_sdout), 64'd1);
        check("single_lrclk_left", 64'(i2s_lrclk), 64'd0);
        wait_until(en + 1 + 10 * 16 + 3);
        enable = 1'b0;
        wait_until(en + 1024);
        check("drop_last_sck_high", 64'(i2s_sck), 64'd1);
        check("drop_last_lrclk", 64'(i2s_lrclk), 64'd1);
        tick();
        check("drop_idle_sck", 64'(i2s_sck), 64'd0);
        check("drop_idle_lrclk", 64'(i2s_lrclk), 64'd0);
        check("drop_idle_sdout", 64'(i2s_sdout), 64'd0);
        check("drop_no_reload", 64'(frame_start), 64'd0);
        repeat (100) tick();
        check("single_sck_count", 64'(rise_t.size()), 64'd64);
        if (rise_t.size() >= 64) begin
            check("single_first_rise", 64'(rise_t[0]), 64'(en + 9));
            check("single_sck_period", 64'(rise_t[1] - rise_t[0]), 64'd16);
            check("single_frame_span", 64'(rise_t[63] - rise_t[0]), 64'd1008);
        end
        check("single_fs_count", 64'(fs_cnt - base_fs), 64'd1);
        check("single_ur_count", 64'(ur_cnt - base_ur), 64'd0);
        wait_frames(base_rx + 1, 10, "single");
        check_frame(base_rx, 24'hA5A5A5, 24'h5A5A5A, 1'b0, "single");

        // ---- back-to-back from table, then underrun ----
        base_rx = rxq.size();
        base_fs = fs_cnt;
        base_ur = ur_cnt;
        push_pair(vec[0].l, vec[0].r, "b2b_push0", acc_t[0]);
        enable = 1'b1;
        en = cyc;
        fork
            begin
                for (int i = 1; i < NV; i++) begin
                    if (vec[i].supply) push_pair(vec[i].l, vec[i].r, "b2b_push", acc_t[i]);
                end
            end
            begin
                for (int k = 0; k < 6 * FRAME && fs_cnt < base_fs + NV; k++) tick();
                enable = 1'b0;
                wait_frames(base_rx + NV, 2 * FRAME, "b2b");
            end
        join
        check("b2b_accept1_time", 64'(acc_t[1]), 64'(en + 2));
        check("b2b_accept_spacing2", 64'(acc_t[2] - acc_t[1]), 64'(FRAME));
        check("b2b_accept_spacing3", 64'(acc_t[3] - acc_t[2]), 64'(FRAME));
        for (int i = 0; i < NV; i++) begin
            check_frame(base_rx + i, vec[i].exp_l, vec[i].exp_r, vec[i].exp_ur,
                        $sformatf("b2b_frame%0d", i));
        end
        repeat (100) tick();
        check("b2b_fs_count", 64'(fs_cnt - base_fs), 64'(NV));
        check("b2b_ur_count", 64'(ur_cnt - base_ur), 64'd1);

        // ---- handshake in the same cycle as an empty-staging load ----
        base_rx = rxq.size();
        base_ur = ur_cnt;
        enable = 1'b1;
        en = cyc;
        push_pair(24'h00FF00, 24'hFF00FF, "same_push", t);
        check("same_accept_time", 64'(t), 64'(en + 1));
        check("same_underrun_pulse", 64'(underrun), 64'd1);
        check("same_staged", 64'(tx_ready), 64'd0);
        wait_until(en + FRAME + 20);
        enable = 1'b0;
        wait_frames(base_rx + 2, 2 * FRAME, "same");
        check_frame(base_rx, vec[4].exp_l, vec[4].exp_r, 1'b1, "same_frame0");
        check_frame(base_rx + 1, 24'h00FF00, 24'hFF00FF, 1'b0, "same_frame1");
        check("same_ur_count", 64'(ur_cnt - base_ur), 64'd1);

        // ---- reset mid-frame at bit 40 ----
        repeat (20) tick();
        push_pair(24'h111111, 24'hFFFFFF, "rstmid_push0", t);
        enable = 1'b1;
        en = cyc;
        push_pair(24'h222222, 24'h333333, "rstmid_push1", t);
        wait_until(en + 1 + 40 * 16 + 10);
        check("rstmid_pre_sck", 64'(i2s_sck), 64'd1);
        check("rstmid_pre_lrclk", 64'(i2s_lrclk), 64'd1);
        check("rstmid_pre_sdout", 64'(i2s_sdout), 64'd1);
        check("rstmid_pre_staged", 64'(tx_ready), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_sck", 64'(i2s_sck), 64'd0);
        check("rstmid_lrclk", 64'(i2s_lrclk), 64'd0);
        check("rstmid_sdout", 64'(i2s_sdout), 64'd0);
        check("rstmid_ready", 64'(tx_ready), 64'd1);
        repeat (3) tick();
        enable = 1'b0;
        rst = 1'b0;
        rise_t.delete();
        base_fs = fs_cnt;
        repeat (50) tick();
        check("rstmid_ready_after", 64'(tx_ready), 64'd1);
        check("rstmid_no_sck", 64'(rise_t.size()), 64'd0);
        check("rstmid_no_frame", 64'(fs_cnt - base_fs), 64'd0);
        check("underrun_without_frame_start", 64'(ur_alone), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
